// File: rtl/prog_load_arbiter_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the arbiter and its byte assembler.
package prog_load_arbiter_pkg;

   typedef enum logic [2:0] {
      RUN,
      COLLECT,
      WRITE,
      FINISH,
      ERROR
   } state_t;

   localparam int ByteIdxW = 2;
   localparam int DefTimeout = 1_000_000;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/prog_load_arbiter_byte_assembler.sv
// Packs received bytes little-endian into a 32-bit word.
// word_valid rises once all four bytes of a word are held.
module byte_assembler
   import prog_load_arbiter_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                byte_en,
   input  logic [7:0]          byte_in,
   output logic [31:0]         word,
   output logic [ByteIdxW-1:0] byte_idx,
   output logic                word_valid
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         word       <= ZeroWord;
         byte_idx   <= '0;
         word_valid <= 1'b0;
      end else if (byte_en) begin
         // shift right so the first byte ends up in bits 7:0
         word       <= {byte_in, word[31:8]};
         byte_idx   <= byte_idx + ByteIdxW'(1);
         word_valid <= (byte_idx == '1);
      end
   end

endmodule

// File: rtl/prog_load_arbiter.sv
// Instruction-memory port arbiter: CPU fetch in RUN,
// UART word writes while a program load is in progress.
module prog_load_arbiter
   import prog_load_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 14,
   parameter int TIMEOUT = DefTimeout
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_req,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_we,
   output logic [31:0]       rom_wdata,
   output logic              cpu_stall,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int TmoW = $clog2(TIMEOUT + 1);

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   waddr;
   logic [TmoW-1:0]     tmo;
   logic                err_q;
   logic                accept;
   logic                tmo_hit;
   logic                clear;
   logic                we_int;
   logic [31:0]         word;
   logic [ByteIdxW-1:0] idx;
   logic                word_valid;

   byte_assembler u_asm (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .byte_en    (accept),
      .byte_in    (rx_data),
      .word       (word),
      .byte_idx   (idx),
      .word_valid (word_valid)
   );

   // a falling load_req blocks acceptance of a same-cycle byte
   assign accept  = (state == COLLECT) && load_req && rx_valid;
   assign tmo_hit = (idx != '0) && !accept
                 && (tmo == TmoW'(TIMEOUT - 1));

   always_comb begin
      state_nx  = state;
      rx_ready  = 1'b0;
      cpu_stall = 1'b1;
      we_int    = 1'b0;
      rom_addr  = waddr;
      load_done = 1'b0;
      clear     = 1'b0;
      unique case (state)
         RUN: begin
            cpu_stall = 1'b0;
            rom_addr  = cpu_addr;
            if (load_req) begin
               state_nx = COLLECT;
               clear    = 1'b1;
            end
         end
         COLLECT: begin
            rx_ready = load_req;
            if (!load_req)
               state_nx = (idx == '0) ? FINISH : ERROR;
            else if (tmo_hit)
               state_nx = ERROR;
            else if (accept && idx == '1)
               state_nx = WRITE;
         end
         WRITE: begin
            we_int   = word_valid;
            clear    = 1'b1;
            state_nx = (waddr == '1) ? FINISH : COLLECT;
         end
         FINISH: begin
            load_done = 1'b1;
            state_nx  = RUN;
         end
         ERROR: begin
            clear = 1'b1;
            if (!load_req) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   assign rom_we    = we_int && !reset;
   assign rom_wdata = rom_we ? word : ZeroWord;
   assign load_err  = err_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RUN;
         waddr      <= '0;
         word_count <= '0;
         tmo        <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == RUN && load_req) begin
            waddr      <= '0;
            word_count <= '0;
            err_q      <= 1'b0;
         end
         if (state == WRITE && word_valid) begin
            waddr      <= waddr + ADDR_W'(1);
            word_count <= word_count + (ADDR_W + 1)'(1);
         end
         if (state_nx == ERROR && state != ERROR)
            err_q <= 1'b1;
         if (state == COLLECT && idx != '0 && !accept)
            tmo <= tmo + TmoW'(1);
         else
            tmo <= '0;
      end
   end

endmodule
